// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared lamp encoding, phase enum and small helpers for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10,
    FLASH  = 2'b11
  } phase_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  function automatic int dir_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lamp code of one approach given the phase, whether it is the served one, and blink state.
  function automatic logic [2:0] lamp_code(input phase_e ph, input logic is_cur, input logic blink);
    logic [2:0] code;
    code = LAMP_RED;
    case (ph)
      GREEN:   code = is_cur ? LAMP_GREEN : LAMP_RED;
      YELLOW:  code = is_cur ? LAMP_YELLOW : LAMP_RED;
      ALLRED:  code = LAMP_RED;
      FLASH:   code = blink ? LAMP_DARK : LAMP_RED;
      default: code = LAMP_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor-side requests and lamp-side status of the phase controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_DIR = 4
);
  import traffic_pkg::*;

  localparam int DIR_W = dir_w(NUM_DIR);

  logic [NUM_DIR-1:0]   car_det;
  logic [NUM_DIR-1:0]   gap_req;
  logic                 flash_mode;
  logic [3*NUM_DIR-1:0] lights;
  logic [DIR_W-1:0]     cur_dir;
  logic [1:0]           phase;

  modport master (
    output car_det, gap_req, flash_mode,
    input  lights, cur_dir, phase
  );

  modport slave (
    input  car_det, gap_req, flash_mode,
    output lights, cur_dir, phase
  );

endinterface

// File: rtl/traffic_phase_ctrl_rr_next_dir.sv
// Round-robin search for the next demanded approach, starting just after cur_dir.
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = dir_w(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] demand,
  input  logic [DIR_W-1:0]   cur_dir,
  output logic [DIR_W-1:0]   next,
  output logic               any
);

  logic [DIR_W-1:0]   w_idx [NUM_DIR];
  logic [NUM_DIR-1:0] w_rot;

  // w_rot[k] is the demand of the approach k+1 steps after cur_dir; offset NUM_DIR is cur_dir itself.
  generate
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_rot
      assign w_idx[gi] = DIR_W'((int'(cur_dir) + gi + 1) % NUM_DIR);
      assign w_rot[gi] = demand[w_idx[gi]];
    end
  endgenerate

  always_comb begin
    next = cur_dir;
    for (int k = NUM_DIR - 1; k >= 0; k--) begin
      if (w_rot[k]) next = w_idx[k];
    end
    any = |demand;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated round-robin traffic phase controller: green/yellow/all-red per approach plus flash mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MAX = 16,
  parameter int GREEN_MIN = 4,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int FLASH_T   = 8
) (
  input logic                 clk,
  input logic                 rst_a,
  traffic_phase_ctrl_if.slave ctrl_if
);

  localparam int DIR_W = dir_w(NUM_DIR);
  localparam logic [CNT_W-1:0] GREEN_LAST    = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] GREEN_MIN_LST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST    = CNT_W'(FLASH_T - 1);

  phase_e             r_phase, w_phase_next;
  logic [DIR_W-1:0]   r_cur_dir, w_cur_dir_next, w_rr_next, w_dir_inc;
  logic [CNT_W-1:0]   r_timer, w_timer_next;
  logic [NUM_DIR-1:0] r_demand, w_demand_next, w_cur_onehot, w_clear, w_lit;
  logic               r_blink, w_blink_next, r_first, w_first_next;
  logic               w_rr_any, w_other, w_green_last, w_green_min_ok, w_green_end;

  rr_next_dir #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_rr (
    .demand  (r_demand),
    .cur_dir (r_cur_dir),
    .next    (w_rr_next),
    .any     (w_rr_any)
  );

  assign w_cur_onehot   = NUM_DIR'(1) << r_cur_dir;
  assign w_dir_inc      = DIR_W'((int'(r_cur_dir) + 1) % NUM_DIR);
  assign w_other        = |(r_demand & ~w_cur_onehot);
  // r_first marks only the opening cycle of a green, not a rest-on-green restart.
  assign w_clear        = (r_phase == GREEN && r_first) ? w_cur_onehot : '0;
  assign w_demand_next  = (r_demand & ~w_clear) | ctrl_if.car_det;
  assign w_green_last   = (r_timer == GREEN_LAST);
  assign w_green_min_ok = (r_timer >= GREEN_MIN_LST);
  assign w_green_end    = (ctrl_if.flash_mode && w_green_min_ok) ||
                          (w_other && (w_green_last || (ctrl_if.gap_req[r_cur_dir] && w_green_min_ok)));

  always_comb begin
    w_phase_next   = r_phase;
    w_cur_dir_next = r_cur_dir;
    w_timer_next   = r_timer;
    w_blink_next   = r_blink;
    w_first_next   = 1'b0;
    case (r_phase)
      GREEN: begin
        if (w_green_end) begin
          w_phase_next = YELLOW;
          w_timer_next = '0;
        end else if (w_green_last) begin
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
      end
      YELLOW: begin
        if (r_timer == YELLOW_LAST) begin
          w_phase_next = ALLRED;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
      end
      ALLRED: begin
        if (r_timer == ALLRED_LAST) begin
          w_timer_next = '0;
          if (ctrl_if.flash_mode) begin
            w_phase_next = FLASH;
            w_blink_next = 1'b0;
          end else begin
            w_phase_next   = GREEN;
            w_cur_dir_next = w_rr_any ? w_rr_next : w_dir_inc;
            w_first_next   = 1'b1;
          end
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
      end
      FLASH: begin
        // Parking on the last approach makes the next pick search from approach 0.
        if (!ctrl_if.flash_mode) begin
          w_phase_next   = ALLRED;
          w_timer_next   = '0;
          w_cur_dir_next = DIR_W'(NUM_DIR - 1);
        end else if (r_timer == FLASH_LAST) begin
          w_timer_next = '0;
          w_blink_next = ~r_blink;
        end else begin
          w_timer_next = r_timer + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_phase   <= GREEN;
      r_cur_dir <= '0;
      r_timer   <= '0;
      r_demand  <= '0;
      r_blink   <= 1'b0;
      r_first   <= 1'b1;
    end else begin
      r_phase   <= w_phase_next;
      r_cur_dir <= w_cur_dir_next;
      r_timer   <= w_timer_next;
      r_demand  <= w_demand_next;
      r_blink   <= w_blink_next;
      r_first   <= w_first_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
      assign ctrl_if.lights[3*gi +: 3] = lamp_code(r_phase, r_cur_dir == DIR_W'(gi), r_blink);
      assign w_lit[gi] = ctrl_if.lights[3*gi] | ctrl_if.lights[3*gi+1];
    end
  endgenerate

  assign ctrl_if.cur_dir = r_cur_dir;
  assign ctrl_if.phase   = r_phase;

  a_single_go: assert property (@(posedge clk) disable iff (rst_a) $onehot0(w_lit));

endmodule
